// File: rtl/reg_share_pkg.sv
// Shared constants and helpers for the register-sharing arbiter.
package reg_share_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;

    // Index width for n requesters; never below one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotate-and-find-first: first asserted req at or after ptr, wrapping.
module rr_priority_pick
    import reg_share_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int ID_WIDTH = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] idx,
    output logic                hit
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [ID_WIDTH:0]    sum;

    // Doubling the vector makes the shift a modulo-NUM_REQ rotation.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        hit = 1'b0;
        sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                hit = 1'b1;
                sum = {1'b0, ptr} + (ID_WIDTH+1)'(k);
            end
        end
        if (sum >= (ID_WIDTH+1)'(NUM_REQ))
            sum = sum - (ID_WIDTH+1)'(NUM_REQ);
        idx = sum[ID_WIDTH-1:0];
    end

    always_comb begin
        grant = '0;
        if (hit) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter feeding one shared, tagged output register.
// Optional lock feature: define REG_SHARE_LOCK_EN to add req_lock.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ID_WIDTH   = clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
`ifdef REG_SHARE_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_WIDTH-1:0]           out_id,
    input  logic                          out_ready
);

    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   win;
    logic                  hit;
    logic                  load;
    logic                  go;
    logic [DATA_WIDTH-1:0] din [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign din[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .hit   (hit)
    );

    assign load      = !out_valid || out_ready;
    assign go        = load && hit && !reset;
    assign req_ready = go ? grant : '0;

    always_comb begin
        if (win == ID_WIDTH'(NUM_REQ - 1))
            ptr_nxt = '0;
        else
            ptr_nxt = win + ID_WIDTH'(1);
`ifdef REG_SHARE_LOCK_EN
        // A locked winner keeps top priority for its next request.
        if (req_lock[win]) ptr_nxt = win;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            ptr       <= '0;
        end else if (go) begin
            out_valid <= 1'b1;
            out_data  <= din[win];
            out_id    <= win;
            ptr       <= ptr_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter (NUM_REQ=4, DATA_WIDTH=8).
module tb_reg_share_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_lock;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_id;
    logic            out_ready;

    int n_cmp;
    int n_err;

    reg_share_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
`ifdef REG_SHARE_LOCK_EN
        .req_lock  (req_lock),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [IW-1:0] id,
                           input logic [DW-1:0] d);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".id"}, 32'(out_id), 32'(id));
        chk({tag, ".data"}, 32'(out_data), 32'(d));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        req_valid = 4'hF;
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_lock  = '0;
        out_ready = 1'b1;

        // reset with everyone requesting
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst.valid", 32'(out_valid), 32'd0);
            chk("rst.data", 32'(out_data), 32'd0);
            chk("rst.id", 32'(out_id), 32'd0);
            chk("rst.ready", 32'(req_ready), 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst.ready", 32'(req_ready), 32'h1);

        // rotation 0,1,2,3,0
        step(); chk_out("rot0", 2'd0, 8'h10);
        chk("rot0.ready", 32'(req_ready), 32'h2);
        step(); chk_out("rot1", 2'd1, 8'h11);
        step(); chk_out("rot2", 2'd2, 8'h12);
        step(); chk_out("rot3", 2'd3, 8'h13);
        step(); chk_out("rot4", 2'd0, 8'h10);

        // backpressure, ptr now 1
        out_ready = 1'b0;
        #1;
        chk("bp.ready0", 32'(req_ready), 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk_out("bp.hold", 2'd0, 8'h10);
            chk("bp.ready", 32'(req_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release", 32'(req_ready), 32'h2);
        step(); chk_out("bp.next", 2'd1, 8'h11);

        // sparse and wrap, ptr now 2
        req_valid = 4'b1000;
        #1;
        chk("sp.ready3", 32'(req_ready), 32'h8);
        step(); chk_out("sp.g3", 2'd3, 8'h13);
        req_valid = 4'b0010;
        #1;
        chk("sp.ready1", 32'(req_ready), 32'h2);
        step(); chk_out("sp.g1", 2'd1, 8'h11);

        // idle drain, ptr stays 2
        req_valid = 4'b0000;
        #1;
        chk("idle.ready", 32'(req_ready), 32'h0);
        step();
        chk("idle.valid", 32'(out_valid), 32'd0);
        step();
        chk("idle.valid2", 32'(out_valid), 32'd0);
        req_valid = 4'hF;
        #1;
        chk("idle.ptr", 32'(req_ready), 32'h4);
        step(); chk_out("idle.g2", 2'd2, 8'h12);

        // reset mid-operation discards held word and ptr
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        chk("mrst.ready", 32'(req_ready), 32'h0);
        step();
        chk("mrst.valid", 32'(out_valid), 32'd0);
        chk("mrst.id", 32'(out_id), 32'd0);
        chk("mrst.data", 32'(out_data), 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mrst.ready0", 32'(req_ready), 32'h1);

`ifdef REG_SHARE_LOCK_EN
        req_valid = 4'b0100;
        req_lock  = 4'b0100;
        step(); chk_out("lk.g0", 2'd2, 8'h12);
        req_valid = 4'b0101;
        step(); chk_out("lk.g1", 2'd2, 8'h12);
        step(); chk_out("lk.g2", 2'd2, 8'h12);
        req_lock = 4'b0000;
        step(); chk_out("lk.last", 2'd2, 8'h12);
        step(); chk_out("lk.after", 2'd0, 8'h10);
`else
        req_valid = 4'b0101;
        step(); chk_out("rr.g0", 2'd0, 8'h10);
        step(); chk_out("rr.g2", 2'd2, 8'h12);
        step(); chk_out("rr.g0b", 2'd0, 8'h10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
